// File: rtl/arbitro_memoria_compartilhada_pkg.sv
// Shared encodings for the shared-memory arbiter: FSM states, grant owner, counter width.
package arbitro_memoria_compartilhada_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ACESSO   = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  typedef enum logic {
    DONO_IF = 1'b0,
    DONO_D  = 1'b1
  } dono_t;

  // Wide enough for both MEM_LAT-1 and MAX_CONSEC (each at most 15).
  localparam int CNT_W = 4;

endpackage

// File: rtl/arbitro_memoria_compartilhada_contador_fome.sv
// Saturating starvation counter: how many data grants were given while fetch was waiting.
module contador_fome
  import arbitro_memoria_compartilhada_pkg::*;
#(
  parameter int MAX_CONSEC = 4
) (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic limpa_i,
  input  logic inc_i,
  output logic saturado_o
);

  logic [CNT_W-1:0] fome_q, fome_d;

  assign saturado_o = (fome_q == CNT_W'(MAX_CONSEC));

  always_comb begin
    fome_d = fome_q;
    if (limpa_i) begin
      fome_d = '0;
    end else if (inc_i && !saturado_o) begin
      fome_d = fome_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      fome_q <= '0;
    end else begin
      fome_q <= fome_d;
    end
  end

endmodule

// File: rtl/arbitro_memoria_compartilhada.sv
// Arbitrates the single-port shared memory between instruction fetch and the MEM-stage data port.
// Data has priority; the starvation counter forces a fetch grant after MAX_CONSEC data grants.
module arbitro_memoria_compartilhada
  import arbitro_memoria_compartilhada_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int MAX_CONSEC = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_ler,
  output logic          mem_esc,
  input  logic [DW-1:0] mem_rdata
);

  estado_t          estado_q, estado_d;
  dono_t            dono_q, dono_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ler_q, ler_d, esc_q, esc_d;
  logic             if_ack_q, if_ack_d, d_ack_q, d_ack_d;
  logic [DW-1:0]    if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;

  logic fome_saturada;
  logic ganha_d, ganha_if;
  logic fome_inc, fome_limpa;

  // Data wins unless fetch has already waited through MAX_CONSEC data grants.
  assign ganha_d    = d_req && !(if_req && fome_saturada);
  assign ganha_if   = !ganha_d && if_req;
  assign fome_inc   = (estado_q == OCIOSO) && ganha_d && if_req;
  assign fome_limpa = (estado_q == OCIOSO) && (ganha_if || !if_req);

  contador_fome #(
    .MAX_CONSEC(MAX_CONSEC)
  ) u_contador_fome (
    .clock_i   (clock),
    .reset_ni  (reset_n),
    .limpa_i   (fome_limpa),
    .inc_i     (fome_inc),
    .saturado_o(fome_saturada)
  );

  always_comb begin
    estado_d   = estado_q;
    dono_d     = dono_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    ler_d      = ler_q;
    esc_d      = esc_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    unique case (estado_q)
      OCIOSO: begin
        ler_d = 1'b0;
        esc_d = 1'b0;
        if (ganha_d) begin
          dono_d   = DONO_D;
          we_d     = d_we;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          cnt_d    = CNT_W'(MEM_LAT - 1);
          ler_d    = !d_we;
          esc_d    = d_we;
          estado_d = ACESSO;
        end else if (ganha_if) begin
          dono_d   = DONO_IF;
          we_d     = 1'b0;
          addr_d   = if_addr;
          cnt_d    = CNT_W'(MEM_LAT - 1);
          ler_d    = 1'b1;
          estado_d = ACESSO;
        end
      end
      ACESSO: begin
        if (cnt_q == '0) begin
          // Last access cycle: memory data is valid now, ack goes out next cycle.
          if (!we_q) begin
            if (dono_q == DONO_D) d_rdata_d  = mem_rdata;
            else                  if_rdata_d = mem_rdata;
          end
          ler_d    = 1'b0;
          esc_d    = 1'b0;
          d_ack_d  = (dono_q == DONO_D);
          if_ack_d = (dono_q == DONO_IF);
          estado_d = RESPOSTA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESPOSTA: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
        ler_d    = 1'b0;
        esc_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q   <= OCIOSO;
      dono_q     <= DONO_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      ler_q      <= 1'b0;
      esc_q      <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      estado_q   <= estado_d;
      dono_q     <= dono_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      ler_q      <= ler_d;
      esc_q      <= esc_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_ler   = ler_q;
  assign mem_esc   = esc_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_stall  = if_req & ~if_ack_q;
  assign d_stall   = d_req & ~d_ack_q;

endmodule

// File: tb/tb_arbitro_memoria_compartilhada.sv
// Directed bench: instance A runs with MEM_LAT=1, instance B with MEM_LAT=3.
module tb_arbitro_memoria_compartilhada;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        rst_n_a, if_req_a, d_req_a, d_we_a;
  logic [31:0] if_addr_a, d_addr_a, d_wdata_a, mem_rdata_a;
  logic        if_ack_a, if_stall_a, d_ack_a, d_stall_a, mem_ler_a, mem_esc_a;
  logic [31:0] if_rdata_a, d_rdata_a, mem_addr_a, mem_wdata_a;

  logic        rst_n_b, if_req_b, d_req_b, d_we_b;
  logic [31:0] if_addr_b, d_addr_b, d_wdata_b, mem_rdata_b;
  logic        if_ack_b, if_stall_b, d_ack_b, d_stall_b, mem_ler_b, mem_esc_b;
  logic [31:0] if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b;

  arbitro_memoria_compartilhada #(.AW(32), .DW(32), .MEM_LAT(1), .MAX_CONSEC(4)) u_a (
    .clock(clk), .reset_n(rst_n_a),
    .if_req(if_req_a), .if_addr(if_addr_a), .if_ack(if_ack_a), .if_rdata(if_rdata_a),
    .if_stall(if_stall_a),
    .d_req(d_req_a), .d_we(d_we_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a), .d_ack(d_ack_a),
    .d_rdata(d_rdata_a), .d_stall(d_stall_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_ler(mem_ler_a), .mem_esc(mem_esc_a),
    .mem_rdata(mem_rdata_a)
  );

  arbitro_memoria_compartilhada #(.AW(32), .DW(32), .MEM_LAT(3), .MAX_CONSEC(4)) u_b (
    .clock(clk), .reset_n(rst_n_b),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_ack(if_ack_b), .if_rdata(if_rdata_b),
    .if_stall(if_stall_b),
    .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b), .d_ack(d_ack_b),
    .d_rdata(d_rdata_b), .d_stall(d_stall_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_ler(mem_ler_b), .mem_esc(mem_esc_b),
    .mem_rdata(mem_rdata_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_both;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    if_req_a = 0; d_req_a = 0; d_we_a = 0; if_addr_a = 0; d_addr_a = 0; d_wdata_a = 0; mem_rdata_a = 0;
    if_req_b = 0; d_req_b = 0; d_we_b = 0; if_addr_b = 0; d_addr_b = 0; d_wdata_b = 0; mem_rdata_b = 0;
    tick();
    tick();
    @(negedge clk);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    if_req_a = 0; d_req_a = 0; if_req_b = 0; d_req_b = 0;
    #3;
    n_checks++;
    if ({if_ack_a, d_ack_a, mem_ler_a, mem_esc_a, if_stall_a, d_stall_a} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl_a: got %b required 000000",
               {if_ack_a, d_ack_a, mem_ler_a, mem_esc_a, if_stall_a, d_stall_a});
    end
    n_checks++;
    if ({if_rdata_a, d_rdata_a, mem_addr_a, mem_wdata_a} !== 128'b0) begin
      n_fail++;
      $display("FAIL reset_data_a: got %h required 0", {if_rdata_a, d_rdata_a, mem_addr_a, mem_wdata_a});
    end
    reset_both();
    n_checks++;
    if ({if_ack_b, d_ack_b, mem_ler_b, mem_esc_b, if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b} !== 132'b0) begin
      n_fail++;
      $display("FAIL reset_b: got %h required 0",
               {if_ack_b, d_ack_b, mem_ler_b, mem_esc_b, if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b});
    end
    $display("reset: outputs idle after reset");
  endtask

  // Fetch only, MEM_LAT=1: strobe in cycle 1, ack in cycle 2.
  task automatic test_fetch_only;
    mem_rdata_a = 32'h2010_0005;
    if_addr_a   = 32'h40;
    if_req_a    = 1'b1;
    #1;
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) tick();
      n_checks++;
      if (mem_ler_a !== (c == 1) || mem_esc_a !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_strobe c=%0d: ler=%b esc=%b required ler=%b esc=0", c, mem_ler_a, mem_esc_a, c == 1);
      end
      n_checks++;
      if (if_ack_a !== (c == 2)) begin
        n_fail++;
        $display("FAIL fetch_ack c=%0d: got %b required %b", c, if_ack_a, c == 2);
      end
      n_checks++;
      if (if_stall_a !== (c < 2)) begin
        n_fail++;
        $display("FAIL fetch_stall c=%0d: got %b required %b", c, if_stall_a, c < 2);
      end
      if (c == 1) begin
        n_checks++;
        if (mem_addr_a !== 32'h40) begin
          n_fail++;
          $display("FAIL fetch_addr: got %h required 00000040", mem_addr_a);
        end
      end
      if (c == 2) begin
        n_checks++;
        if (if_rdata_a !== 32'h2010_0005) begin
          n_fail++;
          $display("FAIL fetch_rdata: got %h required 20100005", if_rdata_a);
        end
        $display("fetch: addr=40 rdata=%h ack at cycle %0d", if_rdata_a, c);
        if_req_a = 1'b0;
      end
    end
  endtask

  // Data read then write on MEM_LAT=3; the write must leave d_rdata alone.
  task automatic test_data_write;
    d_we_b = 1'b0; d_addr_b = 32'h80; mem_rdata_b = 32'h1234_5678; d_req_b = 1'b1;
    #1;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) tick();
      n_checks++;
      if (mem_ler_b !== (c >= 1 && c <= 3) || d_ack_b !== (c == 4) || d_stall_b !== (c != 4)) begin
        n_fail++;
        $display("FAIL read_seq c=%0d: ler=%b ack=%b stall=%b required %b %b %b", c, mem_ler_b, d_ack_b,
                 d_stall_b, c >= 1 && c <= 3, c == 4, c != 4);
      end
    end
    n_checks++;
    if (d_rdata_b !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL read_rdata: got %h required 12345678", d_rdata_b);
    end
    $display("data read: addr=80 rdata=%h", d_rdata_b);
    d_req_b = 1'b0;
    tick();

    d_we_b = 1'b1; d_addr_b = 32'h100; d_wdata_b = 32'hDEAD_BEEF; mem_rdata_b = 32'hCAFE_F00D;
    d_req_b = 1'b1;
    #1;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) tick();
      n_checks++;
      if (mem_esc_b !== (c >= 1 && c <= 3) || mem_ler_b !== 1'b0) begin
        n_fail++;
        $display("FAIL write_strobe c=%0d: esc=%b ler=%b required esc=%b ler=0", c, mem_esc_b, mem_ler_b,
                 c >= 1 && c <= 3);
      end
      n_checks++;
      if (d_ack_b !== (c == 4)) begin
        n_fail++;
        $display("FAIL write_ack c=%0d: got %b required %b", c, d_ack_b, c == 4);
      end
      if (c == 2) begin
        n_checks++;
        if (mem_addr_b !== 32'h100 || mem_wdata_b !== 32'hDEAD_BEEF) begin
          n_fail++;
          $display("FAIL write_bus: addr=%h wdata=%h required 00000100 deadbeef", mem_addr_b, mem_wdata_b);
        end
      end
    end
    n_checks++;
    if (d_rdata_b !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL write_rdata_kept: got %h required 12345678", d_rdata_b);
    end
    $display("data write: addr=100 wdata=deadbeef acked");
    d_req_b = 1'b0;
    tick();
  endtask

  // Simultaneous requests: data first (ack cycle 4), fetch next (ack cycle 9).
  task automatic test_simultaneous;
    int d_cyc, f_cyc;
    d_cyc = -1; f_cyc = -1;
    reset_both();
    d_we_b = 1'b0; d_addr_b = 32'h200; if_addr_b = 32'h44;
    d_req_b = 1'b1; if_req_b = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) tick();
      mem_rdata_b = 32'h1111_0000 + 32'(c);
      if (c == 1) begin
        n_checks++;
        if (mem_addr_b !== 32'h200 || mem_ler_b !== 1'b1) begin
          n_fail++;
          $display("FAIL simul_first_grant: addr=%h ler=%b required 00000200 1", mem_addr_b, mem_ler_b);
        end
      end
      if (c == 6) begin
        n_checks++;
        if (mem_addr_b !== 32'h44 || mem_ler_b !== 1'b1) begin
          n_fail++;
          $display("FAIL simul_second_grant: addr=%h ler=%b required 00000044 1", mem_addr_b, mem_ler_b);
        end
      end
      if (d_ack_b === 1'b1 && d_cyc < 0) begin
        d_cyc = c;
        $display("simul: d_ack at cycle %0d rdata=%h", c, d_rdata_b);
        n_checks++;
        if (d_rdata_b !== 32'h1111_0003 || if_stall_b !== 1'b1) begin
          n_fail++;
          $display("FAIL simul_d_rdata: rdata=%h if_stall=%b required 11110003 1", d_rdata_b, if_stall_b);
        end
        d_req_b = 1'b0;
      end
      if (if_ack_b === 1'b1 && f_cyc < 0) begin
        f_cyc = c;
        $display("simul: if_ack at cycle %0d rdata=%h", c, if_rdata_b);
        n_checks++;
        if (if_rdata_b !== 32'h1111_0008) begin
          n_fail++;
          $display("FAIL simul_if_rdata: got %h required 11110008", if_rdata_b);
        end
        if_req_b = 1'b0;
      end
    end
    n_checks++;
    if (d_cyc != 4) begin
      n_fail++;
      $display("FAIL simul_d_ack_cycle: got %0d required 4", d_cyc);
    end
    n_checks++;
    if (f_cyc != 9) begin
      n_fail++;
      $display("FAIL simul_if_ack_cycle: got %0d required 9", f_cyc);
    end
    d_req_b = 1'b0; if_req_b = 1'b0;
    tick();
  endtask

  // Both requests held: four data grants, one fetch, and the pattern repeats once the counter clears.
  task automatic test_starvation;
    string exp_seq;
    string got_seq;
    exp_seq = "DDDDFDDDDF";
    got_seq = "";
    reset_both();
    d_we_b = 1'b0; d_addr_b = 32'h300; if_addr_b = 32'h80;
    d_req_b = 1'b1; if_req_b = 1'b1;
    for (int c = 0; c < 60 && got_seq.len() < 10; c++) begin
      tick();
      if (d_ack_b === 1'b1) begin
        got_seq = {got_seq, "D"};
        $display("starve: grant %0d data, ack at cycle %0d", got_seq.len(), c + 1);
      end
      if (if_ack_b === 1'b1) begin
        got_seq = {got_seq, "F"};
        $display("starve: grant %0d fetch, ack at cycle %0d", got_seq.len(), c + 1);
      end
    end
    n_checks++;
    if (got_seq.len() != 10) begin
      n_fail++;
      $display("FAIL starve_count: got %0d acks required 10 within 60 cycles", got_seq.len());
    end
    for (int i = 0; i < 10 && i < got_seq.len(); i++) begin
      n_checks++;
      if (got_seq[i] != exp_seq[i]) begin
        n_fail++;
        $display("FAIL starve_order[%0d]: got %s required %s", i, got_seq, exp_seq);
      end
    end
    d_req_b = 1'b0; if_req_b = 1'b0;
    tick();
    tick();
  endtask

  // Reset pulled mid-access: strobe drops at once, no ack, held request restarts cleanly.
  task automatic test_reset_mid_access;
    int ack_seen;
    ack_seen = 0;
    reset_both();
    d_we_b = 1'b1; d_addr_b = 32'h340; d_wdata_b = 32'h0000_55AA; d_req_b = 1'b1;
    tick();
    tick();
    n_checks++;
    if (mem_esc_b !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre_esc: got %b required 1", mem_esc_b);
    end
    #2;
    rst_n_b = 1'b0;
    #1;
    n_checks++;
    if (mem_esc_b !== 1'b0 || mem_ler_b !== 1'b0 || d_ack_b !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_async: esc=%b ler=%b ack=%b required 0 0 0", mem_esc_b, mem_ler_b, d_ack_b);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (d_ack_b === 1'b1) ack_seen++;
    end
    @(negedge clk);
    rst_n_b = 1'b1;
    #1;
    n_checks++;
    if (mem_esc_b !== 1'b0 || d_stall_b !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_idle: esc=%b stall=%b required 0 1", mem_esc_b, d_stall_b);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_checks++;
      if (mem_esc_b !== (c <= 3) || d_ack_b !== (c == 4)) begin
        n_fail++;
        $display("FAIL abort_regrant c=%0d: esc=%b ack=%b required %b %b", c, mem_esc_b, d_ack_b, c <= 3, c == 4);
      end
      if (c == 4) begin
        $display("abort: write to 340 re-granted and acked after reset release");
        d_req_b = 1'b0;
      end
    end
    n_checks++;
    if (ack_seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_ack: got %0d acks during reset required 0", ack_seen);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_data_write();
    test_simultaneous();
    test_starvation();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
